// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: operation codes,
// FSM states and the default iteration count.
package muldiv_pkg;

  localparam int ITER_COUNT_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10
  } state_t;

  function automatic logic op_is_div(op_t o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(op_t o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add for multiply,
// restoring shift-subtract for divide, on a 64-bit {hi,lo} accumulator.
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_nxt
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        borrow;

  always_comb begin
    sum     = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'h0)};
    // Partial remainder after the left shift can need 33 bits before the compare.
    rem_sh  = acc[63:31];
    borrow  = (rem_sh < {1'b0, opnd});
    diff    = rem_sh[31:0] - opnd;
    acc_nxt = {sum, acc[31:1]};
    if (is_div) begin
      acc_nxt = borrow ? {acc[62:0], 1'b0} : {diff, acc[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide unit with hi/lo result registers,
// flush, and MTHI/MTLO style direct writes.
//
// state    | meaning
// ST_IDLE  | waiting for start; hi/lo writable via hi_we/lo_we
// ST_CALC  | ITER_COUNT unsigned arithmetic steps on the operand magnitudes
// ST_FIXUP | sign correction, hi/lo update, done next cycle
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int ITER_COUNT = ITER_COUNT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITER_COUNT + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [63:0]       acc, acc_step, prod;
  logic [31:0]       opnd, mag1, mag2, quo, rem, res_hi, res_lo;
  op_t               op_in, op_q;
  logic              sgn, neg1, neg2;

  muldiv_step u_step (
    .is_div  (op_is_div(op_q)),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_step)
  );

  always_comb begin
    op_in = op_t'(op);
    sgn   = op_is_signed(op_in);
    mag1  = (sgn && data1[31]) ? -data1 : data1;
    mag2  = (sgn && data2[31]) ? -data2 : data2;
  end

  // Divide by zero falls out of the step as {dividend, all-ones}; re-applying the
  // dividend sign to hi restores the operand exactly as presented.
  always_comb begin
    prod   = (neg1 ^ neg2) ? -acc : acc;
    quo    = (neg1 ^ neg2) ? -acc[31:0] : acc[31:0];
    rem    = neg1 ? -acc[63:32] : acc[63:32];
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (op_is_div(op_q)) begin
      res_hi = rem;
      res_lo = (opnd == 32'h0) ? 32'hFFFF_FFFF : quo;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && !flush) state_nxt = ST_CALC;
      ST_CALC: begin
        if (flush)                                 state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(ITER_COUNT - 1))   state_nxt = ST_FIXUP;
      end
      ST_FIXUP: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      op_q  <= OP_MULT;
      neg1  <= 1'b0;
      neg2  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= (state == ST_FIXUP) && !flush;
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            op_q <= op_in;
            neg1 <= sgn & data1[31];
            neg2 <= sgn & data2[31];
            cnt  <= '0;
            acc  <= op_is_div(op_in) ? {32'h0, mag1} : {32'h0, mag2};
            opnd <= op_is_div(op_in) ? mag2 : mag1;
          end
        end
        ST_CALC: begin
          if (!flush) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FIXUP: begin
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized
// back-to-back operations against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        reset, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] data1, data2, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_seq #(.ITER_COUNT(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .data1 (data1),
    .data2 (data2),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    int    sa, sb;
    longint sp;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        return 64'(sp);
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    data1 = a;
    data2 = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // c0 = number of cycles of the current operation already elapsed.
  task automatic finish_op(input string tag, input logic [63:0] exp, input int c0);
    int c;
    bit seen;
    c = c0;
    seen = 1'b0;
    while (!seen && c < ITER + 8) begin
      @(negedge clk);
      c++;
      chk({tag, "_busy"}, 64'(busy), 64'(c >= 1 && c <= ITER + 1));
      if (done) begin
        seen = 1'b1;
        chk({tag, "_lat"}, 64'(c), 64'(ITER + 2));
        chk({tag, "_hilo"}, {hi, lo}, exp);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'b00;
    data1 = '0;
    data2 = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_bd", {62'h0, busy, done}, 64'h0);
    #2 reset = 1'b0;

    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 64'hFFFF_FFFE_0000_0001, 0);
    start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    finish_op("mult_neg", 64'hFFFF_FFFF_FFFF_FFF1, 0);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg", 64'hFFFF_FFFF_FFFF_FFFD, 0);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 64'h0000_0000_8000_0000, 0);
    start_op(2'b11, 32'd100, 32'd0);
    finish_op("divu_zero", 64'h0000_0064_FFFF_FFFF, 0);

    // flush in cycle 10
    start_op(2'b01, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'h0);
    chk("flush_done", 64'(done), 64'h0);
    chk("flush_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    start_op(2'b01, 32'd7, 32'd6);
    finish_op("after_flush", 64'd42, 0);

    // start and hi/lo writes while busy must be ignored
    start_op(2'b01, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    op    = 2'b11;
    data1 = 32'd1000;
    data2 = 32'd7;
    start = 1'b1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    finish_op("busy_ign", 64'd12, 5);
    repeat (3) @(negedge clk);
    chk("no_queue", {62'h0, busy, done}, 64'h0);
    chk("busy_ign_hold", {hi, lo}, 64'd12);

    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("idle_write", {hi, lo}, 64'h1234_5678_1234_5678);

    // write accepted alongside start, then overwritten by the result
    hi_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    start_op(2'b01, 32'd2, 32'd3);
    hi_we = 1'b0;
    chk("we_start", {hi, lo}, 64'hA5A5_A5A5_1234_5678);
    finish_op("we_start_op", 64'd6, 0);
    repeat (20) @(negedge clk);
    chk("hold", {hi, lo}, 64'd6);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
      start_op(ro, ra, rb);
      finish_op($sformatf("rand%0d_op%0d", i, ro), ref_model(ro, ra, rb), 0);
    end

    // asynchronous reset mid-CALC
    start_op(2'b00, 32'hFFFF_1234, 32'd77);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    chk("rst_mid_bd", {62'h0, busy, done}, 64'h0);
    #1 reset = 1'b0;
    start_op(2'b10, 32'hFFFF_FF9C, 32'd7);
    finish_op("after_rst", ref_model(2'b10, 32'hFFFF_FF9C, 32'd7), 0);
    chk("after_rst_const", {hi, lo}, 64'hFFFF_FFFE_FFFF_FFF2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL provide parameter ITER_COUNT, default 32, the number of iteration cycles per operation.
REQ-002 The block SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL provide port start, input, 1, a one-cycle operation request.
REQ-005 The block SHALL provide port op, input, 2, the operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL provide ports data1 and data2, input, 32 each, the operands (multiplicand/dividend, multiplier/divisor).
REQ-007 The block SHALL provide port flush, input, 1, to abort any in-flight operation.
REQ-008 The block SHALL provide ports hi_we, lo_we, input, 1 each, and wdata, input, 32, for MTHI/MTLO writes.
REQ-009 The block SHALL provide ports busy and done, output, 1 each, and hi and lo, output, 32 each, registered.

Function
REQ-010 The block SHALL implement FSM states IDLE, CALC, FIXUP.
REQ-011 In IDLE with start=1 and flush=0, the block SHALL latch op, the operand magnitudes (absolute values for MULT/DIV, raw for MULTU/DIVU) and the result signs, clear the iteration counter, and enter CALC.
REQ-012 CALC SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly ITER_COUNT cycles, then enter FIXUP.
REQ-013 FIXUP SHALL apply sign correction, write hi/lo, and return to IDLE.
REQ-014 Multiply SHALL produce the 64-bit product as hi=[63:32] and lo=[31:0], two's complement for MULT.
REQ-015 Divide SHALL produce the quotient in lo and the remainder in hi, with the signed quotient truncated toward zero and the remainder taking the dividend's sign.
REQ-016 Signed -2^31 / -1 SHALL give lo=0x80000000 and hi=0.
REQ-017 Divide by zero (DIV or DIVU) SHALL give lo=0xFFFFFFFF and hi=data1 as latched, with unchanged latency and no sign correction.
REQ-018 For a start accepted in cycle 0, busy SHALL be 1 in cycles 1..ITER_COUNT+1 and 0 otherwise.
REQ-019 For a start accepted in cycle 0, done SHALL pulse 1 for exactly cycle ITER_COUNT+2, with hi/lo valid from that cycle.
REQ-020 A start accepted in cycle ITER_COUNT+2 SHALL be honoured, giving back-to-back operation.
REQ-021 While busy=1, start SHALL be ignored and produce no queuing and no error.
REQ-022 flush=1 in CALC or FIXUP SHALL return the FSM to IDLE at the next edge with hi/lo unchanged and no done pulse.
REQ-023 flush in IDLE SHALL have no effect, and flush SHALL take priority over a simultaneous start.
REQ-024 In IDLE, hi_we SHALL load hi and lo_we SHALL load lo from wdata at the next edge; both may be written in the same cycle.
REQ-025 While busy=1, hi_we and lo_we SHALL be ignored.
REQ-026 When hi_we/lo_we and an accepted start occur in the same IDLE cycle, the write SHALL occur and the operation SHALL later overwrite both registers.
REQ-027 Between operations, hi and lo SHALL hold their value indefinitely.

Reset
REQ-028 Asserting reset SHALL, asynchronously and regardless of state (including mid-CALC), force FSM=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-029 After reset deasserts, the first rising edge SHALL accept start.

Structure
REQ-030 Op encodings, FSM state encodings and ITER_COUNT default SHALL reside in shared package muldiv_pkg, also used by the decoder.
REQ-031 The per-cycle arithmetic step (64-bit accumulator shift, conditional add/subtract) SHALL be sub-module muldiv_step, purely combinational, with sequencing and sign handling in muldiv_seq.

Verification
REQ-032 The bench SHALL check MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly in cycle 34, busy high cycles 1..33.
REQ-033 The bench SHALL check MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 The bench SHALL check DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; and DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-035 The bench SHALL check start in cycle 0 then flush in cycle 10 -> busy=0 in cycle 11, no done, hi/lo retain prior values; start in cycle 11 accepted.
REQ-036 The bench SHALL check start while busy and hi_we while busy -> both ignored, result unchanged; hi_we/lo_we in IDLE with wdata=0x12345678 -> hi=lo=0x12345678 next cycle.
REQ-037 The bench SHALL check reset asserted mid-CALC, between clock edges -> all outputs 0 immediately; a new operation after release completes with correct results.
